// File: rtl/status_pkg.sv
// Shared definitions for the status-word unit: flag positions inside the
// CPSR, condition-code encodings, processor mode encodings and FSM states.
package status_pkg;

  // Bit positions of the arithmetic flags inside the 32-bit status word.
  localparam int FLAG_N = 31;
  localparam int FLAG_Z = 30;
  localparam int FLAG_C = 29;
  localparam int FLAG_V = 28;

  // Condition-field encodings of the ID-stage instruction.
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // CPSR[4:0] mode encodings.
  localparam logic [4:0] MODE_USR_ENC = 5'b10000;
  localparam logic [4:0] MODE_IRQ_ENC = 5'b10010;

  // Exception FSM: normal operation or inside an exception handler.
  typedef enum logic [0:0] {
    ST_USR = 1'b0,
    ST_IRQ = 1'b1
  } st_t;

endpackage

// File: rtl/status_reg_unit_cond_check.sv
// Condition-code evaluator: decides whether an instruction with the given
// 4-bit condition field may execute under the supplied {N,Z,C,V} flags.
module cond_check
  import status_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_ok
);

  logic w_n;
  logic w_z;
  logic w_c;
  logic w_v;

  assign w_n = i_flags[3];
  assign w_z = i_flags[2];
  assign w_c = i_flags[1];
  assign w_v = i_flags[0];

  // Decode the condition field against the flags.
  always_comb begin
    o_ok = 1'b0;
    case (i_cond)
      COND_EQ: o_ok = w_z;
      COND_NE: o_ok = ~w_z;
      COND_CS: o_ok = w_c;
      COND_CC: o_ok = ~w_c;
      COND_MI: o_ok = w_n;
      COND_PL: o_ok = ~w_n;
      COND_VS: o_ok = w_v;
      COND_VC: o_ok = ~w_v;
      COND_HI: o_ok = w_c & ~w_z;
      COND_LS: o_ok = ~w_c | w_z;
      COND_GE: o_ok = (w_n == w_v);
      COND_LT: o_ok = (w_n != w_v);
      COND_GT: o_ok = ~w_z & (w_n == w_v);
      COND_LE: o_ok = w_z | (w_n != w_v);
      COND_AL: o_ok = 1'b1;
      COND_NV: o_ok = 1'b0;
      default: o_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/status_reg_unit.sv
// Processor status word owner: captures ALU flags on S-bit instructions,
// evaluates the ID-stage condition field and saves/restores the CPSR
// through the SPSR on exception entry and return.
module status_reg_unit
  import status_pkg::*;
#(
  parameter logic       BYPASS   = 1'b1,
  parameter logic [4:0] MODE_USR = MODE_USR_ENC,
  parameter logic [4:0] MODE_IRQ = MODE_IRQ_ENC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        exe_valid,
  input  logic        exe_s,
  input  logic [3:0]  exe_status_bits,
  input  logic [3:0]  id_cond,
  input  logic        exc_enter,
  input  logic        exc_return,
  output logic        cond_ok,
  output logic [31:0] status_reg_out,
  output logic [31:0] spsr_out,
  output logic        in_exc,
  output logic        nest_err
);

  // State registers.
  st_t         r_state;
  logic [3:0]  r_flags;
  logic [4:0]  r_mode;
  logic [31:0] r_spsr;
  logic        r_in_exc;
  logic        r_nest_err;

  // Next-state values.
  st_t         w_state_nxt;
  logic [3:0]  w_flags_nxt;
  logic [4:0]  w_mode_nxt;
  logic [31:0] w_spsr_nxt;
  logic        w_in_exc_nxt;
  logic        w_nest_err_nxt;

  // Request decode.
  logic        w_wr_flags;
  logic [3:0]  w_eff_flags;
  logic        w_enter_ok;
  logic        w_return_ok;
  logic        w_req_any;
  logic [31:0] w_cpsr;

  assign w_wr_flags  = exe_valid & exe_s & ~freeze;
  assign w_req_any   = exc_enter | exc_return;
  assign w_enter_ok  = (r_state == ST_USR) & exc_enter & ~exc_return;
  assign w_return_ok = (r_state == ST_IRQ) & exc_return & ~exc_enter;

  // Flags seen by the condition check: the ones being written this cycle
  // when bypassing, otherwise the registered copy.
  always_comb begin
    w_eff_flags = r_flags;
    if (BYPASS && w_wr_flags) begin
      w_eff_flags = exe_status_bits;
    end else begin
      w_eff_flags = r_flags;
    end
  end

  // Assemble the full CPSR image from flags and mode; other bits read 0.
  always_comb begin
    w_cpsr                 = 32'h0000_0000;
    w_cpsr[FLAG_N:FLAG_V]  = r_flags;
    w_cpsr[4:0]            = r_mode;
  end

  cond_check u_cond_check (
    .i_cond  (id_cond),
    .i_flags (w_eff_flags),
    .o_ok    (cond_ok)
  );

  // Next-state logic: flag capture, exception entry/return and nesting errors.
  always_comb begin
    w_state_nxt    = r_state;
    w_flags_nxt    = r_flags;
    w_mode_nxt     = r_mode;
    w_spsr_nxt     = r_spsr;
    w_in_exc_nxt   = r_in_exc;
    w_nest_err_nxt = 1'b0;
    if (freeze) begin
      w_nest_err_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_USR: begin
          if (w_wr_flags) begin
            w_flags_nxt = exe_status_bits;
          end else begin
            w_flags_nxt = r_flags;
          end
          if (w_enter_ok) begin
            w_spsr_nxt                   = w_cpsr;
            w_spsr_nxt[FLAG_N:FLAG_V]    = w_eff_flags;
            w_mode_nxt                   = MODE_IRQ;
            w_state_nxt                  = ST_IRQ;
          end else begin
            w_state_nxt = ST_USR;
          end
        end
        ST_IRQ: begin
          if (w_return_ok) begin
            // Restore wins over a flag write in the same cycle.
            w_flags_nxt = r_spsr[FLAG_N:FLAG_V];
            w_mode_nxt  = r_spsr[4:0];
            w_state_nxt = ST_USR;
          end else if (w_wr_flags) begin
            w_flags_nxt = exe_status_bits;
          end else begin
            w_flags_nxt = r_flags;
          end
        end
        default: begin
          w_state_nxt = ST_USR;
          w_mode_nxt  = MODE_USR;
        end
      endcase
      w_in_exc_nxt   = (w_state_nxt == ST_IRQ);
      w_nest_err_nxt = w_req_any & ~w_enter_ok & ~w_return_ok;
    end
  end

  // State register with asynchronous reset to normal mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_USR;
      r_flags    <= 4'h0;
      r_mode     <= MODE_USR;
      r_spsr     <= 32'h0000_0000;
      r_in_exc   <= 1'b0;
      r_nest_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_flags    <= w_flags_nxt;
      r_mode     <= w_mode_nxt;
      r_spsr     <= w_spsr_nxt;
      r_in_exc   <= w_in_exc_nxt;
      r_nest_err <= w_nest_err_nxt;
    end
  end

  assign status_reg_out = w_cpsr;
  assign spsr_out       = r_spsr;
  assign in_exc         = r_in_exc;
  assign nest_err       = r_nest_err;

endmodule
